// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: binary-to-BCD converter with multiplexed 7-segment scanning.
// Define SEG7_LZB_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int DIGITS   = 2,
  parameter int WIDTH    = 7,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);
  // Five BCD digits hold any 14-bit value, so overflow is just "any digit above DIGITS nonzero".
  localparam int BW = 20;
  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  logic [PW-1:0]     pre_q;
  logic [IW-1:0]     idx_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BW-1:0]     bcd_q, adj;
  logic [BW:0]       bcd_d;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     dig_q;
  logic              busy_q, ovf_q, tc, last, blank;
  logic [3:0]        cur;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b0111111;
      4'd1: dec = 7'b0000110;
      4'd2: dec = 7'b1011011;
      4'd3: dec = 7'b1001111;
      4'd4: dec = 7'b1100110;
      4'd5: dec = 7'b1101101;
      4'd6: dec = 7'b1111101;
      4'd7: dec = 7'b0000111;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1101111;
      default: dec = 7'b0000000;
    endcase
  endfunction
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BW / 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bcd_d = {adj, bin_q[WIDTH-1]};
  end
  assign tc   = pre_q == PW'(SCAN_DIV - 1);
  assign last = cnt_q == CW'(WIDTH - 1);
  assign cur  = dig_q[4*idx_q +: 4];
`ifdef SEG7_LZB_EN
  logic [DW-1:0] hi;
  assign hi    = dig_q >> {idx_q, 2'b00};
  assign blank = idx_q != '0 && hi == '0;
`else
  assign blank = 1'b0;
`endif
  assign seg_d = ovf_q ? 7'b1000000 : blank ? 7'b0000000 : dec(cur);
  assign an_d  = DIGITS'(1) << idx_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      idx_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      dig_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      seg_q  <= 7'b0111111;
      an_q   <= DIGITS'(1);
    end else begin
      pre_q <= tc ? '0 : pre_q + 1'b1;
      idx_q <= tc ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
      seg_q <= seg_d;
      an_q  <= an_d;
      if (busy_q) begin
        bin_q <= bin_q << 1;
        bcd_q <= bcd_d[BW-1:0];
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          busy_q <= 1'b0;
          dig_q  <= bcd_d[DW-1:0];
          ovf_q  <= |bcd_d[BW:DW];
        end
      end else if (load) begin
        bin_q  <= value;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end
  assign seg      = seg_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench for seg7_scan_driver (DIGITS=2, WIDTH=7, SCAN_DIV=4).
module tb_seg7_scan_driver;
  logic       clk = 0, reset = 1, load = 0;
  logic [6:0] value = '0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy, overflow;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, next_ok = 0;
  int exp_q[$];
  int j = 0, blen = 0, disp_v = 0, pend_v = 0;
  bit disp_o = 0, o_out = 0, pend = 0, rst_prev = 1;

  seg7_scan_driver #(.DIGITS(2), .WIDTH(7), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .seg(seg), .an(an), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit ov, input int d);
    int dig;
    if (ov) return 7'b1000000;
    dig = (d == 0) ? v % 10 : (v / 10) % 10;
`ifdef SEG7_LZB_EN
    if (d > 0 && v / 10 == 0) return 7'b0000000;
`endif
    case (dig)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  // Monitor: reset read here is the level the DUT sampled at the previous posedge.
  always @(negedge clk) begin
    int idx;
    int v;
    bit s_rst;
    s_rst = rst_prev;
    rst_prev = reset;
    if (s_rst) begin
      j = 0;
      exp_q.delete();
      disp_v = 0;
      disp_o = 0;
      o_out = 0;
      pend = 0;
      blen = 0;
      chk(busy == 1'b0, "busy_rst", int'(busy), 0);
    end else begin
      j++;
      if (pend) begin
        disp_v = pend_v;
        disp_o = pend_o_get();
        pend = 0;
      end
      if (busy) blen++;
      else if (blen > 0) begin
        chk(exp_q.size() > 0, "unexpected_conv", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          v = exp_q.pop_front();
          chk(blen == 7, "busy_len", blen, 7);
          o_out = v > 99;
          pend = 1;
          pend_v = v;
        end
        blen = 0;
      end
    end
    idx = (j == 0) ? 0 : ((j - 1) / 4) % 2;
    chk(an == (idx ? 2'b10 : 2'b01), "an", int'(an), idx ? 2 : 1);
    chk(seg == exp_seg(disp_v, disp_o, idx), "seg", int'(seg), int'(exp_seg(disp_v, disp_o, idx)));
    chk(overflow == o_out, "overflow", int'(overflow), int'(o_out));
  end

  function automatic bit pend_o_get();
    return pend_v > 99;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    value = 7'(v);
    load = 1;
    if (cyc + 1 >= next_ok) begin
      exp_q.push_back(v);
      next_ok = cyc + 9;
    end
    tick();
    load = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) tick();
    reset = 0;
    next_ok = cyc + 1;
  endtask

  initial begin
    tick();
    do_reset(3);
    repeat (3) tick();
    do_load(42);
    repeat (20) tick();
    do_load(100);
    repeat (20) tick();
    do_load(5);
    repeat (20) tick();
    do_load(7);
    tick();
    do_load(99);
    repeat (20) tick();
    repeat (16) tick();
    do_load(63);
    repeat (2) tick();
    do_reset(1);
    repeat (12) tick();
    for (int k = 0; k < 30; k++) begin
      do_load(int'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 12)) tick();
    end
    do_load(127);
    repeat (30) tick();
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    chk(busy == 1'b0, "idle_end", int'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
